// File: rtl/melody_sequencer_if.sv
// melody_sequencer_if: control, song ROM and tone-generator signals of the melody sequencer.
// MELODY_TEMPO_ADJ_EN adds the tempo_sel input.
interface melody_sequencer_if #(parameter int ADDR_W = 6);
  logic start;
  logic stop;
  logic loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0] rom_data;
  logic [6:0] full_note;
  logic play;
  logic busy;
  logic done;
`ifdef MELODY_TEMPO_ADJ_EN
  logic [1:0] tempo_sel;
  modport master (output start, stop, loop_en, rom_data, tempo_sel, input rom_addr, full_note, play, busy, done);
  modport slave (input start, stop, loop_en, rom_data, tempo_sel, output rom_addr, full_note, play, busy, done);
`else
  modport master (output start, stop, loop_en, rom_data, input rom_addr, full_note, play, busy, done);
  modport slave (input start, stop, loop_en, rom_data, output rom_addr, full_note, play, busy, done);
`endif
endinterface

// File: rtl/melody_sequencer.sv
// melody_sequencer: walks a song ROM and drives full_note/play for the piano tone generator.
// Defining MELODY_TEMPO_ADJ_EN adds tempo_sel (half/double speed), sampled at DECODE.
module melody_sequencer #(
  parameter int ADDR_W = 6,
  parameter int UNIT_TICKS = 781250,
  parameter int GAP_TICKS = 2500000
) (
  input logic clk,
  input logic reset_n,
  melody_sequencer_if.slave bus
);
  localparam int DW = $clog2(255 * UNIT_TICKS * 2);
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam int CW = DW > GW ? DW : GW;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, NOTE, GAP} state_t;
  state_t r_state, w_state;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [6:0] r_note, w_note;
  logic r_play, w_play, r_busy, w_busy, r_done, w_done;
  logic [CW-1:0] r_cnt, w_cnt, w_unit, w_load;
  logic [7:0] w_dur;
  logic w_adv, w_end;
`ifdef MELODY_TEMPO_ADJ_EN
  assign w_unit = bus.tempo_sel == 2'b01 ? CW'(2 * UNIT_TICKS) :
                  bus.tempo_sel == 2'b10 ? CW'(UNIT_TICKS > 1 ? UNIT_TICKS / 2 : 1) : CW'(UNIT_TICKS);
`else
  assign w_unit = CW'(UNIT_TICKS);
`endif
  assign w_dur = bus.rom_data[7:0] == 8'd0 ? 8'd1 : bus.rom_data[7:0];
  assign w_load = CW'(w_dur) * w_unit - CW'(1);
  // the last cycle of a note's gap doubles as the advance step into the next fetch
  assign w_adv = r_cnt == '0 && (r_state == GAP || (r_state == NOTE && GAP_TICKS == 0));
  assign w_end = (r_state == DECODE && bus.rom_data[15]) || (w_adv && &r_addr);
  always_comb begin
    w_state = r_state;
    w_addr = r_addr;
    w_note = r_note;
    w_play = r_play;
    w_busy = r_busy;
    w_done = 1'b0;
    w_cnt = r_cnt;
    case (r_state)
      IDLE: if (bus.start) begin w_state = FETCH; w_addr = '0; w_busy = 1'b1; end
      FETCH: w_state = DECODE;
      DECODE: if (!bus.rom_data[15]) begin
        w_state = NOTE;
        w_note = bus.rom_data[14:8];
        w_play = bus.rom_data[11:8] == 4'd0 || bus.rom_data[11:8] > 4'd12;
        w_cnt = w_load;
      end
      NOTE: if (r_cnt != '0) w_cnt = r_cnt - CW'(1);
        else if (GAP_TICKS != 0) begin w_state = GAP; w_play = 1'b1; w_cnt = CW'(GAP_TICKS - 1); end
      GAP: if (r_cnt != '0) w_cnt = r_cnt - CW'(1);
      default: w_state = IDLE;
    endcase
    if (w_adv) begin w_state = FETCH; w_addr = r_addr + ADDR_W'(1); w_play = 1'b1; end
    if (w_end) begin
      w_state = bus.loop_en ? FETCH : IDLE;
      w_addr = bus.loop_en ? '0 : r_addr;
      w_note = bus.loop_en ? r_note : '0;
      w_busy = bus.loop_en;
      w_done = !bus.loop_en;
      w_play = 1'b1;
    end
    if (bus.stop) begin
      w_state = IDLE;
      w_addr = '0;
      w_note = '0;
      w_play = 1'b1;
      w_busy = 1'b0;
      w_done = 1'b0;
      w_cnt = '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_note <= '0;
      r_play <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state;
      r_addr <= w_addr;
      r_note <= w_note;
      r_play <= w_play;
      r_busy <= w_busy;
      r_done <= w_done;
      r_cnt <= w_cnt;
    end
  end
  assign bus.rom_addr = r_addr;
  assign bus.full_note = r_note;
  assign bus.play = r_play;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: scoreboard bench; expected (full_note, play, length) runs are queued per song
// and compared against run-length-compressed DUT output.
module tb_melody_sequencer;
  localparam int G = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  melody_sequencer_if #(.ADDR_W(4)) bus();
  melody_sequencer #(.ADDR_W(4), .UNIT_TICKS(4), .GAP_TICKS(G)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  logic [15:0] rom [16];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
  typedef struct packed {logic [6:0] note; logic play; logic [31:0] len;} run_t;
  run_t exp_q[$];
  bit done_q[$];
  int n_chk = 0, n_bad = 0, n_done = 0, n_done_exp = 0, unit = 4, m_tot = 0, m_lim = 0, cur_len = 0;
  bit m_cap = 0, mon_en = 0;
  logic [8:0] cur_key, k;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add(input logic [6:0] n, input logic p, input int len);
    run_t r;
    if (m_lim > 0 && m_tot + len >= m_lim) begin len = m_lim - m_tot; m_cap = 1; end
    if (len <= 0) return;
    m_tot += len;
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1].note == n && exp_q[exp_q.size()-1].play == p) begin
      r = exp_q.pop_back();
      r.len += len;
      exp_q.push_back(r);
    end else exp_q.push_back('{note: n, play: p, len: len});
  endtask

  // busy cycles counted from the first FETCH cycle; limit>0 truncates where stop lands
  task automatic model(input bit lp, input int limit, output bit nat);
    int a = 0, d;
    logic [15:0] w;
    logic [6:0] cur = '0;
    nat = 0; m_tot = 0; m_lim = limit; m_cap = 0;
    add(7'h00, 1'b1, 2);
    for (int g = 0; g < 200 && !m_cap; g++) begin
      w = rom[a];
      if (w[15]) begin
        if (!lp) begin nat = 1; break; end
        add(cur, 1'b1, 2); a = 0;
      end else begin
        d = w[7:0] == 8'd0 ? 1 : int'(w[7:0]);
        cur = w[14:8];
        add(cur, cur[3:0] == 4'd0 || cur[3:0] > 4'd12, d * unit);
        if (a == 15) begin
          add(cur, 1'b1, G);
          if (!lp) begin nat = !m_cap; break; end
          add(cur, 1'b1, 2); a = 0;
        end else begin add(cur, 1'b1, G + 2); a++; end
      end
    end
  endtask

  task automatic end_run();
    run_t e;
    bit d = 0;
    if (cur_key[8]) begin
      if (exp_q.size() == 0) chk("run_extra", 32'(cur_len), 0);
      else begin
        e = exp_q.pop_front();
        chk("run_note", 32'(cur_key[7:1]), 32'(e.note));
        chk("run_play", 32'(cur_key[0]), 32'(e.play));
        chk("run_len", 32'(cur_len), e.len);
      end
      if (!bus.busy) begin
        if (done_q.size() > 0) d = done_q.pop_front();
        chk("done_pulse", 32'(bus.done), 32'(d));
      end
    end else chk("idle_out", 32'(cur_key[7:0]), 32'h01);
  endtask

  initial forever begin
    @(negedge clk);
    if (!mon_en) cur_len = 0;
    else begin
      k = {bus.busy, bus.full_note, bus.play};
      if (cur_len > 0 && k != cur_key) end_run();
      if (cur_len > 0 && k == cur_key) cur_len++;
      else begin cur_key = k; cur_len = 1; end
      if (bus.done === 1'b1) n_done++;
    end
  end

  task automatic wait_idle();
    int i = 0;
    while (bus.busy !== 1'b0 && i < 3000) begin @(posedge clk); #1; i++; end
    chk("idle_timeout", 32'(bus.busy), 0);
  endtask

  task automatic play_song(input bit lp, input int limit, input int poke, input bit both);
    bit nat;
    int last;
    model(lp, limit, nat);
    done_q.push_back(nat);
    n_done_exp += int'(nat);
    bus.loop_en = lp;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    last = limit > poke ? limit : poke;
    for (int c = 1; c <= last; c++) begin
      bus.start = c == poke || (both && c == limit);
      bus.stop = c == limit;
      @(posedge clk); #1 bus.start = 1'b0; bus.stop = 1'b0;
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1 chk("queue_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_note"}, 32'(bus.full_note), 0);
    chk({tag, "_play"}, 32'(bus.play), 1);
    chk({tag, "_addr"}, 32'(bus.rom_addr), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  initial begin
    bit found = 0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;
`ifdef MELODY_TEMPO_ADJ_EN
    bus.tempo_sel = 2'b00;
`endif
    for (int i = 0; i < 16; i++) rom[i] = 16'h8000;
    repeat (3) @(posedge clk);
    #1 idle_checks("rst");
    chk("rst_done", 32'(bus.done), 0);
    #1 reset_n = 1'b1;
    mon_en = 1;
    rom[0] = 16'h0A03; rom[1] = 16'h8000;
    play_song(0, 0, 0, 0);
    rom[0] = 16'h2102; rom[1] = 16'h0001; rom[2] = 16'h8000;
    play_song(0, 0, 9, 0);
    play_song(1, 50, 20, 0);
    idle_checks("loopstop");
    rom[0] = 16'h0A03; rom[1] = 16'h8000; rom[2] = 16'h8000;
    play_song(0, 7, 0, 1);
    idle_checks("stopstart");
    rom[0] = 16'h0500;
    play_song(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) rom[i] = {4'h1, 4'(i % 12 + 1), 8'h01};
    rom[7] = 16'h0D01;
    play_song(0, 0, 0, 0);
    chk("nowrap_addr", 32'(bus.rom_addr), 15);
`ifdef MELODY_TEMPO_ADJ_EN
    rom[0] = 16'h0A03; rom[1] = 16'h8000;
    bus.tempo_sel = 2'b10; unit = 2;
    play_song(0, 0, 0, 0);
    bus.tempo_sel = 2'b00; unit = 4;
`endif
    rom[0] = 16'h0A03; rom[1] = 16'h8000;
    mon_en = 0;
    bus.loop_en = 1'b0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      found = bus.busy && bus.play && bus.full_note == 7'h0A;
    end
    chk("gap_reached", 32'(found), 1);
    #2 reset_n = 1'b0;
    #1 idle_checks("rstgap");
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    mon_en = 1;
    repeat (4) @(posedge clk);
    #1 chk("done_count", 32'(n_done), 32'(n_done_exp));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream driver for the piano tone generator.
- Walks a song table held in an external synchronous ROM. Each entry is a note code plus a duration.
- Presents each note on full_note and holds the tone generator's play input low for that duration, with a short muted gap between notes.
- Supports start/stop control, optional looping, and a one-cycle done pulse at the end of the song.

Parameters:
- ADDR_W, 6, song ROM address width. The table has 2^ADDR_W entries.
- UNIT_TICKS, 781250, clk cycles per duration unit (1/64 s at 50 MHz).
- GAP_TICKS, 2500000, clk cycles of muted gap after each note. 0 means no gap.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins playback from address 0 when idle.
- stop  in  1  one-cycle pulse; aborts playback.
- loop_en  in  1  level; when high, the END entry restarts the song at address 0.
- rom_addr  out  ADDR_W  song ROM address, registered.
- rom_data  in  16  ROM word. Valid one clk after rom_addr changes.
- full_note  out  7  {octave[2:0], note[3:0]}. note 1..12 = C..B, 0 = silent.
- play  out  1  tone generator mute. 1 = silent / counter held, 0 = sounding.
- busy  out  1  high from the first cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse on normal song end (not on stop).

Behaviour:
- ROM word format: [15] END marker, [14:8] full_note, [7:0] duration in units.
- Reset values (async, immediate): state IDLE, rom_addr=0, full_note=0, play=1, busy=0, done=0, all counters 0.
- States:
  - IDLE. start → FETCH with rom_addr=0, busy=1.
  - FETCH. One wait cycle for ROM latency; then → DECODE.
  - DECODE. Samples rom_data.
    - END=1 and loop_en=1 → rom_addr=0, FETCH.
    - END=1 and loop_en=0 → IDLE, done=1 for one cycle, busy=0, full_note=0, play=1.
    - END=0 → latch full_note; load the duration counter with max(dur,1)*UNIT_TICKS − 1; → NOTE.
  - NOTE. Outputs held. play=0, except play=1 when note nibble is 0 or >12 (silent or invalid). This avoids a zero reload count downstream. Counter decrements each clk; at 0 → GAP, or → ADVANCE if GAP_TICKS=0.
  - GAP. play=1, full_note unchanged, for exactly GAP_TICKS clks; then → ADVANCE.
  - ADVANCE. rom_addr+1 → FETCH. If rom_addr is already 2^ADDR_W−1, treat as an implicit END: loop_en decides restart vs. done, with no address wrap-through.
- Latency:
  - start sampled at edge N. FETCH during N+1, DECODE at N+2.
  - full_note/play reflect the first entry from edge N+3.
  - A note with duration d sounds for exactly d*UNIT_TICKS clks.
- Control and boundary rules:
  - start while busy: ignored.
  - stop in any state: next clk → IDLE, play=1, full_note=0, rom_addr=0, busy=0, no done pulse.
  - start and stop in the same cycle: stop wins.
  - Duration 0: treated as 1 unit.
  - loop_en is sampled only at DECODE of the END entry (or at the implicit END).
  - Reset mid-note: outputs return to reset values immediately.
- Arithmetic: duration counter width is ceil(log2(255*UNIT_TICKS*2)) bits; the factor of 2 covers the tempo option. No overflow for any legal entry.

Optional Feature:
- Macro: MELODY_TEMPO_ADJ_EN.
- When defined:
  - Adds input tempo_sel[1:0], sampled at DECODE.
  - 00 = nominal. 01 = half speed (units counted at 2*UNIT_TICKS). 10 = double speed (UNIT_TICKS>>1, minimum 1). 11 = nominal.
  - The gap length is unaffected.
- When undefined: the port is absent and timing is always nominal.

Test Plan:
(All with ADDR_W=4, UNIT_TICKS=4, GAP_TICKS=2.)
- ROM[0]=0x0A03 (A oct0, dur 3), ROM[1]=0x8000; start at edge 0 → edges 3..14: full_note=0x0A, play=0. Edges 15–16: play=1. Done pulse at edge 19; busy low from edge 19; full_note=0.
- ROM[0]=0x2102 (C oct2), ROM[1]=0x0001 (silent), ROM[2]=0x8000 → the silent entry holds play=1 for its 4-clk duration; the 0x21 note shows play=0 for 8 clks.
- Same ROM, loop_en=1 → after the END entry, rom_addr returns to 0 and the note 0x21 replays; done never asserts. Stop → IDLE, play=1, no done.
- Stop asserted mid-NOTE, together with start in the same cycle → next clk play=1, full_note=0, busy=0; the start is ignored.
- Duration byte 0x00 → note sounds 4 clks. All 16 entries non-END → implicit END after address 15; done pulses and rom_addr does not wrap.
- reset_n low mid-GAP → immediately play=1, full_note=0, rom_addr=0, busy=0. With MELODY_TEMPO_ADJ_EN and tempo_sel=10, dur 3 → 6 clks.
